mlsu_addr_gen: RTL and testbench
================================

Name: mlsu_addr_gen

Overview:
Address generator downstream of the MLSU request pre-decoder. It consumes one pre-decoded request per matrix row/column (base address, element width, stride, vl) and emits a stream of bus-aligned memory beat requests with byte enables for the MLSU memory port. Contiguous requests are split at BUS_BYTES boundaries; strided requests produce one beat per element.

Parameters:
BUS_BYTES, 16, memory bus width in bytes; power of two, >= 8
VL_W, 16, width of the vl field (elements per request)
ID_W, 4, width of the request ID

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
preDec_req_valid_i  input  1  pre-decoded request valid
preDec_req_ready_o  output  1  pre-decoded request accepted
req_id_i  input  ID_W  request ID
mode_i  input  2  one-hot mode: bit0 = row-major (strided), bit1 = column-major (contiguous)
base_addr_i  input  64  byte address of element 0
sew_i  input  2  element size = 2^sew_i bytes
stride_i  input  64  byte stride between elements (strided mode only)
vl_i  input  VL_W  element count
is_load_i  input  1  1 = load, 0 = store
mem_req_valid_o  output  1  beat request valid
mem_req_ready_i  input  1  beat request accepted
mem_addr_o  output  64  BUS_BYTES-aligned beat address
mem_byte_en_o  output  BUS_BYTES  active byte lanes
mem_elem_cnt_o  output  $clog2(BUS_BYTES)+1  elements carried in this beat
mem_last_o  output  1  final beat of the request
mem_is_load_o  output  1  latched is_load
mem_req_id_o  output  ID_W  latched request ID
busy_o  output  1  state != S_IDLE

Behaviour:
- Reset: state S_IDLE. All outputs and internal registers 0, except preDec_req_ready_o = 1.
- FSM states: S_IDLE, S_GEN.
- preDec_req_ready_o = (state == S_IDLE); it is not asserted in S_GEN, even during the last beat.
- S_IDLE: on valid and ready, latch all fields.
  - cur_addr = base_addr_i.
  - Contiguous: rem = vl_i << sew_i (bytes).
  - Strided: rem = vl_i (elements).
  - If vl_i != 0, go to S_GEN. If vl_i == 0, stay in S_IDLE and emit no beats; ready stays 1, so the next request can be accepted on the following cycle.
- S_GEN, contiguous:
  - off = cur_addr[log2(BUS_BYTES)-1:0].
  - n = min(rem, BUS_BYTES - off).
  - mem_addr_o = cur_addr with the offset bits cleared.
  - mem_byte_en_o = bits [off, off+n) set.
  - mem_elem_cnt_o = n >> sew.
  - mem_last_o = (rem == n).
- S_GEN, strided:
  - n = 2^sew.
  - mem_addr_o = aligned cur_addr.
  - mem_byte_en_o = n bits set starting at off.
  - mem_elem_cnt_o = 1.
  - mem_last_o = (rem == 1).
- Beat handshake, on valid and ready:
  - Contiguous: cur_addr += n, rem -= n.
  - Strided: cur_addr += stride (64-bit wrap-around), rem -= 1.
  - If mem_last_o, go to S_IDLE.
- mem_req_valid_o = (state == S_GEN). Outputs are driven combinationally from registered state only, never from mem_req_ready_i. While valid is high and ready is low, every output is held stable.
- Latency: the first beat is valid in the cycle after request acceptance. One beat per cycle under no backpressure.
- Address arithmetic wraps modulo 2^64.
- Contiguous beat counts: an aligned base gives ceil(bytes / BUS_BYTES) beats; an unaligned base may add one extra beat.
- Assertions (fatal):
  - On request handshake, mode_i is one-hot.
  - base_addr_i is a multiple of 2^sew_i.
  - In strided mode, stride_i is a multiple of 2^sew_i, so no element straddles a beat.
  - 2^sew_i <= BUS_BYTES.
- Reset asserted mid-request: state returns to S_IDLE immediately (asynchronously), the request is abandoned, and mem_req_valid_o drops to 0 without completing the last beat.

Test Plan:
- Contiguous unaligned: base 0x1006, sew 1, vl 10 -> two beats:
  - addr 0x1000, byte_en 0xFFC0, elem_cnt 5, last 0
  - addr 0x1010, byte_en 0x03FF, elem_cnt 5, last 1; back in S_IDLE next cycle.
- Contiguous aligned: base 0x3000, sew 3, vl 4 -> beats 0x3000 and 0x3010, each byte_en 0xFFFF, elem_cnt 2; last on the second beat.
- Strided: base 0x2004, sew 2, stride 0x40, vl 3 -> addr 0x2000, 0x2040, 0x2080; each byte_en 0x00F0, elem_cnt 1; last on the third beat.
- Backpressure: same stimulus as the strided test with mem_req_ready_i low for 3 cycles on beat 2 -> addr 0x2040 and byte_en held stable; no beat skipped or duplicated; preDec_req_ready_o stays 0.
- vl = 0: request accepted -> mem_req_valid_o never asserts; preDec_req_ready_o = 1 the next cycle; the following request (base 0x4000, sew 0, vl 16) yields one beat at addr 0x4000, byte_en 0xFFFF, elem_cnt 16, last 1.
- Reset mid-request: rst_ni low during beat 1 of the first test -> outputs return to reset values asynchronously; after release, a fresh request is processed correctly from its first beat.

Source files
------------

// File: rtl/mlsu_addr_gen.sv
// MLSU address generator: turns one pre-decoded row/column request into a
// stream of bus-aligned memory beats, each with byte enables and an element count.
module mlsu_addr_gen #(
  parameter int unsigned BUS_BYTES = 16,
  parameter int unsigned VL_W      = 16,
  parameter int unsigned ID_W      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           preDec_req_valid_i,
  output logic                           preDec_req_ready_o,
  input  logic [ID_W-1:0]                req_id_i,
  input  logic [1:0]                     mode_i,
  input  logic [63:0]                    base_addr_i,
  input  logic [1:0]                     sew_i,
  input  logic [63:0]                    stride_i,
  input  logic [VL_W-1:0]                vl_i,
  input  logic                           is_load_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [63:0]                    mem_addr_o,
  output logic [BUS_BYTES-1:0]           mem_byte_en_o,
  output logic [$clog2(BUS_BYTES):0]     mem_elem_cnt_o,
  output logic                           mem_last_o,
  output logic                           mem_is_load_o,
  output logic [ID_W-1:0]                mem_req_id_o,
  output logic                           busy_o
);

  localparam int unsigned OFF_W = $clog2(BUS_BYTES);
  localparam int unsigned CNT_W = OFF_W + 1;
  localparam int unsigned REM_W = VL_W + 4;

  typedef enum logic {S_IDLE, S_GEN} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [63:0]       r_cur_addr;
  logic [63:0]       r_stride;
  logic [REM_W-1:0]  r_rem;
  logic [1:0]        r_sew;
  logic              r_contig;
  logic              r_is_load;
  logic [ID_W-1:0]   r_id;

  logic                 w_req_fire;
  logic                 w_beat_fire;
  logic                 w_gen;
  logic [OFF_W-1:0]     w_off;
  logic [REM_W-1:0]     w_room;
  logic [CNT_W-1:0]     w_n;
  logic [CNT_W-1:0]     w_end;
  logic [CNT_W-1:0]     w_elem_cnt;
  logic                 w_last;
  logic [BUS_BYTES-1:0] w_be;

  assign w_gen       = (r_state == S_GEN);
  assign w_req_fire  = preDec_req_valid_i && preDec_req_ready_o;
  assign w_beat_fire = w_gen && mem_req_ready_i;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and all payload stable until the transfer completes.
  always_comb begin
    w_off  = r_cur_addr[OFF_W-1:0];
    w_room = REM_W'(BUS_BYTES) - REM_W'(w_off);
    if (r_contig) begin
      w_n        = (r_rem < w_room) ? CNT_W'(r_rem) : CNT_W'(w_room);
      w_elem_cnt = w_n >> r_sew;
      w_last     = (r_rem == REM_W'(w_n));
    end else begin
      w_n        = CNT_W'(1) << r_sew;
      w_elem_cnt = CNT_W'(1);
      w_last     = (r_rem == REM_W'(1));
    end
    w_end = CNT_W'(w_off) + w_n;
    w_be  = '0;
    for (int i = 0; i < int'(BUS_BYTES); i++) begin
      w_be[i] = (CNT_W'(i) >= CNT_W'(w_off)) && (CNT_W'(i) < w_end);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_fire && (vl_i != '0)) w_state_nxt = S_GEN;
      S_GEN:  if (w_beat_fire && w_last)      w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Contiguous requests count remaining bytes; strided requests count elements.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_addr <= '0;
      r_stride   <= '0;
      r_rem      <= '0;
      r_sew      <= '0;
      r_contig   <= 1'b0;
      r_is_load  <= 1'b0;
      r_id       <= '0;
    end else if (w_req_fire) begin
      r_cur_addr <= base_addr_i;
      r_stride   <= stride_i;
      r_sew      <= sew_i;
      r_contig   <= mode_i[1];
      r_is_load  <= is_load_i;
      r_id       <= req_id_i;
      r_rem      <= mode_i[1] ? (REM_W'(vl_i) << sew_i) : REM_W'(vl_i);
    end else if (w_beat_fire) begin
      if (r_contig) begin
        r_cur_addr <= r_cur_addr + 64'(w_n);
        r_rem      <= r_rem - REM_W'(w_n);
      end else begin
        r_cur_addr <= r_cur_addr + r_stride;
        r_rem      <= r_rem - REM_W'(1);
      end
    end
  end

  assign preDec_req_ready_o = (r_state == S_IDLE);
  assign mem_req_valid_o    = w_gen;
  assign busy_o             = w_gen;
  assign mem_addr_o         = w_gen ? {r_cur_addr[63:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_byte_en_o      = w_gen ? w_be : '0;
  assign mem_elem_cnt_o     = w_gen ? w_elem_cnt : '0;
  assign mem_last_o         = w_gen && w_last;
  assign mem_is_load_o      = r_is_load;
  assign mem_req_id_o       = r_id;

  a_mode_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_req_fire |-> $onehot(mode_i))
    else $fatal(1, "mode_i not one-hot on request");
  a_base_align: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_req_fire |-> ((base_addr_i & ((64'd1 << sew_i) - 64'd1)) == 64'd0))
    else $fatal(1, "base_addr_i not element aligned");
  a_stride_align: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_req_fire && mode_i[0]) |-> ((stride_i & ((64'd1 << sew_i) - 64'd1)) == 64'd0))
    else $fatal(1, "stride_i not element aligned");
  a_sew_fits: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_req_fire |-> ((32'd1 << sew_i) <= BUS_BYTES))
    else $fatal(1, "element wider than bus");

endmodule

// File: tb/tb_mlsu_addr_gen.sv
// Randomized bench for mlsu_addr_gen: a byte-by-byte reference model builds the
// expected beat list for each request, which is checked beat by beat.
module tb_mlsu_addr_gen;

  localparam int unsigned BUS_BYTES = 16;
  localparam int unsigned VL_W      = 16;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned CNT_W     = $clog2(BUS_BYTES) + 1;
  localparam int unsigned EXP_W     = 64 + BUS_BYTES + CNT_W + 1;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 preDec_req_valid_i;
  logic                 preDec_req_ready_o;
  logic [ID_W-1:0]      req_id_i;
  logic [1:0]           mode_i;
  logic [63:0]          base_addr_i;
  logic [1:0]           sew_i;
  logic [63:0]          stride_i;
  logic [VL_W-1:0]      vl_i;
  logic                 is_load_i;
  logic                 mem_req_valid_o;
  logic                 mem_req_ready_i;
  logic [63:0]          mem_addr_o;
  logic [BUS_BYTES-1:0] mem_byte_en_o;
  logic [CNT_W-1:0]     mem_elem_cnt_o;
  logic                 mem_last_o;
  logic                 mem_is_load_o;
  logic [ID_W-1:0]      mem_req_id_o;
  logic                 busy_o;

  mlsu_addr_gen #(.BUS_BYTES(BUS_BYTES), .VL_W(VL_W), .ID_W(ID_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .preDec_req_valid_i(preDec_req_valid_i), .preDec_req_ready_o(preDec_req_ready_o),
    .req_id_i(req_id_i), .mode_i(mode_i), .base_addr_i(base_addr_i), .sew_i(sew_i),
    .stride_i(stride_i), .vl_i(vl_i), .is_load_i(is_load_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_elem_cnt_o(mem_elem_cnt_o), .mem_last_o(mem_last_o),
    .mem_is_load_o(mem_is_load_o), .mem_req_id_o(mem_req_id_o), .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: walk every byte (contiguous) or element (strided) address
  // and group them by the bus-aligned beat they fall in.
  task automatic build_exp(input logic [1:0] mode, input logic [63:0] base,
                           input logic [1:0] sew, input logic [63:0] stride,
                           input int vl);
    int esz;
    logic [63:0] a, ba, cur_ba;
    logic [BUS_BYTES-1:0] be;
    int nbytes;
    logic [EXP_W-1:0] e;
    esz = 1 << sew;
    exp_q.delete();
    if (vl == 0) return;
    if (mode[1]) begin
      be = '0; nbytes = 0; cur_ba = '0;
      for (int i = 0; i < vl * esz; i++) begin
        a  = base + 64'(i);
        ba = a & ~64'(BUS_BYTES - 1);
        if (i != 0 && ba != cur_ba) begin
          exp_q.push_back({cur_ba, be, CNT_W'(nbytes / esz), 1'b0});
          be = '0; nbytes = 0;
        end
        cur_ba = ba;
        be[a % BUS_BYTES] = 1'b1;
        nbytes++;
      end
      exp_q.push_back({cur_ba, be, CNT_W'(nbytes / esz), 1'b1});
    end else begin
      for (int k = 0; k < vl; k++) begin
        a  = base + stride * 64'(k);
        be = '0;
        for (int b = 0; b < esz; b++) be[(a % BUS_BYTES) + 64'(b)] = 1'b1;
        exp_q.push_back({a & ~64'(BUS_BYTES - 1), be, CNT_W'(1), k == vl - 1});
      end
    end
    e = exp_q[0];
  endtask

  task automatic drive_req(input logic [ID_W-1:0] id, input logic [1:0] mode,
                           input logic [63:0] base, input logic [1:0] sew,
                           input logic [63:0] stride, input int vl, input logic ld);
    @(negedge clk_i);
    check_eq("req_ready_idle", preDec_req_ready_o, 1);
    preDec_req_valid_i = 1'b1;
    req_id_i = id; mode_i = mode; base_addr_i = base; sew_i = sew;
    stride_i = stride; vl_i = VL_W'(vl); is_load_i = ld;
    @(negedge clk_i);
    preDec_req_valid_i = 1'b0;
  endtask

  // stall_at < 0: random ready; otherwise ready high except 3 cycles on beat stall_at
  task automatic run_req(input logic [ID_W-1:0] id, input logic [1:0] mode,
                         input logic [63:0] base, input logic [1:0] sew,
                         input logic [63:0] stride, input int vl, input logic ld,
                         input int stall_at);
    int cycles, beat, stalls;
    logic [EXP_W-1:0] e;
    build_exp(mode, base, sew, stride, vl);
    drive_req(id, mode, base, sew, stride, vl, ld);
    if (vl == 0) begin
      check_eq("vl0_no_valid", mem_req_valid_o, 0);
      check_eq("vl0_ready", preDec_req_ready_o, 1);
      return;
    end
    check_eq("first_beat_latency", mem_req_valid_o, 1);
    cycles = 0; beat = 0; stalls = 0;
    while (exp_q.size() > 0 && cycles < 400) begin
      if (stall_at < 0) mem_req_ready_i = ($urandom_range(0, 3) != 0);
      else if (beat == stall_at && stalls < 3) begin
        mem_req_ready_i = 1'b0; stalls++;
      end else mem_req_ready_i = 1'b1;
      e = exp_q[0];
      check_eq("valid", mem_req_valid_o, 1);
      check_eq("addr", mem_addr_o, e[EXP_W-1 -: 64]);
      check_eq("byte_en", 64'(mem_byte_en_o), 64'(e[CNT_W+1 +: BUS_BYTES]));
      check_eq("elem_cnt", 64'(mem_elem_cnt_o), 64'(e[1 +: CNT_W]));
      check_eq("last", mem_last_o, e[0]);
      check_eq("id", 64'(mem_req_id_o), 64'(id));
      check_eq("is_load", mem_is_load_o, ld);
      check_eq("req_ready_busy", preDec_req_ready_o, 0);
      if (mem_req_ready_i) begin
        void'(exp_q.pop_front());
        beat++;
      end
      @(negedge clk_i);
      cycles++;
    end
    mem_req_ready_i = 1'b0;
    check_eq("beats_outstanding", 64'(exp_q.size()), 0);
    check_eq("idle_after_last", busy_o, 0);
    check_eq("valid_after_last", mem_req_valid_o, 0);
    check_eq("ready_after_last", preDec_req_ready_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, preDec_req_ready_o, 1);
    check_eq({tag, "_valid"}, mem_req_valid_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_addr"}, mem_addr_o, 0);
    check_eq({tag, "_be"}, 64'(mem_byte_en_o), 0);
    check_eq({tag, "_cnt"}, 64'(mem_elem_cnt_o), 0);
    check_eq({tag, "_last"}, mem_last_o, 0);
    check_eq({tag, "_id"}, 64'(mem_req_id_o), 0);
    check_eq({tag, "_ld"}, mem_is_load_o, 0);
  endtask

  initial begin
    logic [1:0]  r_mode, r_sew;
    logic [63:0] r_base, r_stride, esz;
    int          r_vl;
    rst_ni = 1'b0;
    preDec_req_valid_i = 1'b0; mem_req_ready_i = 1'b0;
    req_id_i = '0; mode_i = '0; base_addr_i = '0; sew_i = '0;
    stride_i = '0; vl_i = '0; is_load_i = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // directed cases
    run_req(4'h1, 2'b10, 64'h1006, 2'd1, 64'h0,  10, 1'b1, -1);
    run_req(4'h2, 2'b10, 64'h3000, 2'd3, 64'h0,   4, 1'b0, -1);
    run_req(4'h3, 2'b01, 64'h2004, 2'd2, 64'h40,  3, 1'b1, -1);
    run_req(4'h4, 2'b01, 64'h2004, 2'd2, 64'h40,  3, 1'b0, 1);
    run_req(4'h5, 2'b10, 64'h5000, 2'd0, 64'h0,   0, 1'b1, -1);
    run_req(4'h6, 2'b10, 64'h4000, 2'd0, 64'h0,  16, 1'b1, -1);
    run_req(4'h7, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8, 2'd2, 64'h0, 6, 1'b0, -1);

    // reset in the middle of a request
    drive_req(4'h9, 2'b10, 64'h1006, 2'd1, 64'h0, 10, 1'b1);
    check_eq("pre_reset_valid", mem_req_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_req(4'hA, 2'b10, 64'h1006, 2'd1, 64'h0, 10, 1'b1, -1);

    // random requests
    for (int t = 0; t < 40; t++) begin
      r_mode = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      r_sew  = 2'($urandom_range(0, 3));
      esz    = 64'd1 << r_sew;
      r_base = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) r_base = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
      r_base = r_base & ~(esz - 64'd1);
      case ($urandom_range(0, 2))
        0:       r_stride = esz * 64'($urandom_range(0, 8));
        1:       r_stride = -(esz * 64'($urandom_range(1, 8)));
        default: r_stride = {$urandom, $urandom} & ~(esz - 64'd1);
      endcase
      r_vl = $urandom_range(0, 40);
      run_req(ID_W'($urandom), r_mode, r_base, r_sew, r_stride, r_vl,
              1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
